// File: rtl/grf_pkg.sv
// Shared defaults and trace record widths for the multi-port general register file.
package grf_pkg;

  localparam int unsigned GRF_DATA_W   = 32;
  localparam int unsigned GRF_ADDR_W   = 5;
  localparam int unsigned GRF_PC_W     = 32;
  localparam int unsigned GRF_REG_ZERO = 0;

endpackage

// File: rtl/grf_read_port.sv
// One combinational read port: array select, optional write bypass, zero forcing, busy lookup.
module grf_read_port
  import grf_pkg::*;
#(
  parameter int unsigned DATA_W   = GRF_DATA_W,
  parameter int unsigned ADDR_W   = GRF_ADDR_W,
  parameter int unsigned NWR      = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic [(DATA_W<<ADDR_W)-1:0] regs_flat,
  input  logic [(1<<ADDR_W)-1:0]      busy,
  input  logic [ADDR_W-1:0]           rd_addr,
  input  logic [NWR-1:0]              wr_en,
  input  logic [NWR*ADDR_W-1:0]       wr_addr,
  input  logic [NWR*DATA_W-1:0]       wr_data,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        rd_busy
);

  logic is_zero;

  // Higher-numbered write ports are scanned last so they win the bypass.
  always_comb begin
    is_zero = (ZERO_REG != 0) && (rd_addr == ADDR_W'(GRF_REG_ZERO));
    rd_data = regs_flat[32'(rd_addr) * DATA_W +: DATA_W];
    rd_busy = busy[rd_addr];
    if (BYPASS != 0) begin
      for (int j = 0; j < int'(NWR); j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr)) begin
          rd_data = wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
    if (is_zero) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/grf_mp.sv
// Multi-port register file with prioritised writes, busy scoreboard and registered write trace.
module grf_mp
  import grf_pkg::*;
#(
  parameter int unsigned DATA_W   = GRF_DATA_W,
  parameter int unsigned ADDR_W   = GRF_ADDR_W,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NRD*ADDR_W-1:0]      rd_addr,
  output logic [NRD*DATA_W-1:0]      rd_data,
  output logic [NRD-1:0]             rd_busy,
  input  logic [NWR-1:0]             wr_en,
  input  logic [NWR*ADDR_W-1:0]      wr_addr,
  input  logic [NWR*DATA_W-1:0]      wr_data,
  input  logic [NWR*GRF_PC_W-1:0]    wr_pc,
  input  logic                       sb_set,
  input  logic [ADDR_W-1:0]          sb_addr,
  output logic [NWR-1:0]             trc_valid,
  output logic [NWR*GRF_PC_W-1:0]    trc_pc,
  output logic [NWR*ADDR_W-1:0]      trc_addr,
  output logic [NWR*DATA_W-1:0]      trc_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned PC_W  = GRF_PC_W;

  logic [DATA_W-1:0]       regs_q [DEPTH];
  logic [DATA_W-1:0]       regs_d [DEPTH];
  logic [DEPTH*DATA_W-1:0] regs_flat;
  logic [DEPTH-1:0]        busy_q, busy_d;
  logic [NWR-1:0]          wr_ok;
  logic                    sb_ok;
  logic [NWR-1:0]          trc_valid_q, trc_valid_d;
  logic [NWR*PC_W-1:0]     trc_pc_q, trc_pc_d;
  logic [NWR*ADDR_W-1:0]   trc_addr_q, trc_addr_d;
  logic [NWR*DATA_W-1:0]   trc_data_q, trc_data_d;

  // Writes to the hardwired zero register are dropped before storage, scoreboard and trace.
  always_comb begin
    for (int k = 0; k < int'(NWR); k++) begin
      wr_ok[k] = wr_en[k] &&
                 !((ZERO_REG != 0) && (wr_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(GRF_REG_ZERO)));
    end
    sb_ok = sb_set && !((ZERO_REG != 0) && (sb_addr == ADDR_W'(GRF_REG_ZERO)));
  end

  // Port order gives the last port priority; a same-edge set overrides the write clear.
  always_comb begin
    regs_d      = regs_q;
    busy_d      = busy_q;
    trc_valid_d = wr_ok;
    trc_pc_d    = trc_pc_q;
    trc_addr_d  = trc_addr_q;
    trc_data_d  = trc_data_q;
    for (int k = 0; k < int'(NWR); k++) begin
      if (wr_ok[k]) begin
        regs_d[wr_addr[k*ADDR_W +: ADDR_W]] = wr_data[k*DATA_W +: DATA_W];
        busy_d[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
        trc_pc_d[k*PC_W +: PC_W]            = wr_pc[k*PC_W +: PC_W];
        trc_addr_d[k*ADDR_W +: ADDR_W]      = wr_addr[k*ADDR_W +: ADDR_W];
        trc_data_d[k*DATA_W +: DATA_W]      = wr_data[k*DATA_W +: DATA_W];
      end
    end
    if (sb_ok) begin
      busy_d[sb_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
      busy_q      <= '0;
      trc_valid_q <= '0;
      trc_pc_q    <= '0;
      trc_addr_q  <= '0;
      trc_data_q  <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q      <= busy_d;
      trc_valid_q <= trc_valid_d;
      trc_pc_q    <= trc_pc_d;
      trc_addr_q  <= trc_addr_d;
      trc_data_q  <= trc_data_d;
    end
  end

  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_flat
    assign regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
  end

  for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
    grf_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NWR     (NWR),
      .BYPASS  (BYPASS),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .regs_flat(regs_flat),
      .busy     (busy_q),
      .rd_addr  (rd_addr[k*ADDR_W +: ADDR_W]),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data[k*DATA_W +: DATA_W]),
      .rd_busy  (rd_busy[k])
    );
  end

  assign trc_valid = trc_valid_q;
  assign trc_pc    = trc_pc_q;
  assign trc_addr  = trc_addr_q;
  assign trc_data  = trc_data_q;

endmodule

// File: tb/tb_grf_mp.sv
// Directed bench for grf_mp: a bypassing and a non-bypassing instance share stimulus.
module tb_grf_mp;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned NRD = 2;
  localparam int unsigned NWR = 2;

  localparam int S_RD0   = 0;
  localparam int S_RD1   = 1;
  localparam int S_NBRD0 = 2;
  localparam int S_BUSY  = 3;
  localparam int S_TV    = 4;
  localparam int S_TPC0  = 5;
  localparam int S_TPC1  = 6;
  localparam int S_TA0   = 7;
  localparam int S_TA1   = 8;
  localparam int S_TD0   = 9;
  localparam int S_TD1   = 10;
  localparam int S_NBTV  = 11;

  logic                clk = 1'b0;
  logic                reset;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*DW-1:0]   rd_data, nb_rd_data;
  logic [NRD-1:0]      rd_busy, nb_rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*DW-1:0]   wr_data;
  logic [NWR*32-1:0]   wr_pc;
  logic                sb_set;
  logic [AW-1:0]       sb_addr;
  logic [NWR-1:0]      trc_valid, nb_trc_valid;
  logic [NWR*32-1:0]   trc_pc, nb_trc_pc;
  logic [NWR*AW-1:0]   trc_addr, nb_trc_addr;
  logic [NWR*DW-1:0]   trc_data, nb_trc_data;

  int total = 0;
  int bad   = 0;

  string       tag_q[$];
  int          sel_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  grf_mp #(.BYPASS(1)) u_dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_pc(wr_pc),
    .sb_set(sb_set), .sb_addr(sb_addr), .trc_valid(trc_valid), .trc_pc(trc_pc),
    .trc_addr(trc_addr), .trc_data(trc_data)
  );

  grf_mp #(.BYPASS(0)) u_nb (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_pc(wr_pc),
    .sb_set(sb_set), .sb_addr(sb_addr), .trc_valid(nb_trc_valid), .trc_pc(nb_trc_pc),
    .trc_addr(nb_trc_addr), .trc_data(nb_trc_data)
  );

  function automatic logic [31:0] obs(int sel);
    case (sel)
      S_RD0:   return rd_data[31:0];
      S_RD1:   return rd_data[63:32];
      S_NBRD0: return nb_rd_data[31:0];
      S_BUSY:  return 32'(rd_busy);
      S_TV:    return 32'(trc_valid);
      S_TPC0:  return trc_pc[31:0];
      S_TPC1:  return trc_pc[63:32];
      S_TA0:   return 32'(trc_addr[4:0]);
      S_TA1:   return 32'(trc_addr[9:5]);
      S_TD0:   return trc_data[31:0];
      S_TD1:   return trc_data[63:32];
      S_NBTV:  return 32'(nb_trc_valid);
      default: return 'x;
    endcase
  endfunction

  task automatic expect_v(input string tag, input int sel, input logic [31:0] v);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    exp_q.push_back(v);
  endtask

  task automatic drain();
    while (sel_q.size() > 0) begin
      string       t;
      int          s;
      logic [31:0] e;
      logic [31:0] o;
      t = tag_q.pop_front();
      s = sel_q.pop_front();
      e = exp_q.pop_front();
      o = obs(s);
      total++;
      assert (o === e) else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", t, o, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = '0;
    sb_set = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    rd_addr = '0;
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    wr_pc   = '0;
    sb_set  = 1'b0;
    sb_addr = '0;
    #1;
    expect_v("reset_rd0", S_RD0, 32'h0);
    expect_v("reset_busy", S_BUSY, 32'h0);
    expect_v("reset_tv", S_TV, 32'h0);
    expect_v("reset_tpc0", S_TPC0, 32'h0);
    expect_v("reset_td1", S_TD1, 32'h0);
    drain();
    #1 reset = 1'b1;
    tick();

    // Same-cycle bypass vs. pre-edge value
    wr_en = 2'b01; wr_addr[4:0] = 5'd3; wr_data[31:0] = 32'hDEADBEEF; wr_pc[31:0] = 32'h10;
    rd_addr = {5'd3, 5'd3};
    #1;
    expect_v("byp_rd0", S_RD0, 32'hDEADBEEF);
    expect_v("byp_rd1", S_RD1, 32'hDEADBEEF);
    expect_v("nobyp_rd0_old", S_NBRD0, 32'h0);
    drain();
    tick();
    idle();
    #1;
    expect_v("nobyp_rd0_new", S_NBRD0, 32'hDEADBEEF);
    expect_v("byp_rd0_after", S_RD0, 32'hDEADBEEF);
    expect_v("byp_tv", S_TV, 32'h1);
    expect_v("byp_ta0", S_TA0, 32'd3);
    expect_v("nb_tv", S_NBTV, 32'h1);
    drain();
    tick();
    expect_v("byp_tv_drop", S_TV, 32'h0);
    expect_v("byp_td0_hold", S_TD0, 32'hDEADBEEF);
    drain();

    // Dual write to r9: port 1 wins, both traced
    wr_en = 2'b11; wr_addr = {5'd9, 5'd9}; wr_data = {32'h22, 32'h11};
    wr_pc = {32'h104, 32'h100}; rd_addr = {5'd9, 5'd9};
    #1;
    expect_v("dual_byp_prio", S_RD0, 32'h22);
    expect_v("dual_nb_old", S_NBRD0, 32'h0);
    drain();
    tick();
    idle();
    #1;
    expect_v("dual_r9", S_RD0, 32'h22);
    expect_v("dual_nb_r9", S_NBRD0, 32'h22);
    expect_v("dual_tv", S_TV, 32'h3);
    expect_v("dual_td0", S_TD0, 32'h11);
    expect_v("dual_td1", S_TD1, 32'h22);
    expect_v("dual_tpc0", S_TPC0, 32'h100);
    expect_v("dual_tpc1", S_TPC1, 32'h104);
    expect_v("dual_ta1", S_TA1, 32'd9);
    drain();

    // Zero register: write and scoreboard set both ignored
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data[31:0] = 32'hFFFFFFFF;
    sb_set = 1'b1; sb_addr = 5'd0; rd_addr = {5'd0, 5'd0};
    #1;
    expect_v("zero_byp", S_RD0, 32'h0);
    drain();
    tick();
    idle();
    #1;
    expect_v("zero_rd0", S_RD0, 32'h0);
    expect_v("zero_nb_rd0", S_NBRD0, 32'h0);
    expect_v("zero_busy", S_BUSY, 32'h0);
    expect_v("zero_tv", S_TV, 32'h0);
    drain();

    // Scoreboard race on r4: set wins, lone write then clears
    wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data[31:0] = 32'h44;
    sb_set = 1'b1; sb_addr = 5'd4; rd_addr = {5'd4, 5'd4};
    #1;
    expect_v("race_busy_pre", S_BUSY, 32'h0);
    drain();
    tick();
    sb_set = 1'b0; wr_data[31:0] = 32'h45;
    #1;
    expect_v("race_busy_set", S_BUSY, 32'h3);
    expect_v("race_byp", S_RD0, 32'h45);
    expect_v("race_nb", S_NBRD0, 32'h44);
    drain();
    tick();
    idle();
    #1;
    expect_v("race_busy_clr", S_BUSY, 32'h0);
    expect_v("race_nb_new", S_NBRD0, 32'h45);
    drain();

    // Trace of a single write at r31
    wr_en = 2'b01; wr_addr = {5'd0, 5'd31}; wr_data[31:0] = 32'hCAFE; wr_pc[31:0] = 32'h3000;
    tick();
    idle();
    #1;
    expect_v("trc_tv", S_TV, 32'h1);
    expect_v("trc_pc0", S_TPC0, 32'h3000);
    expect_v("trc_ta0", S_TA0, 32'd31);
    expect_v("trc_td0", S_TD0, 32'hCAFE);
    drain();
    tick();
    expect_v("trc_tv_pulse", S_TV, 32'h0);
    drain();

    // Asynchronous reset mid-operation
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data[31:0] = 32'h1234;
    sb_set = 1'b1; sb_addr = 5'd7; rd_addr = {5'd7, 5'd5};
    tick();
    idle();
    #1;
    expect_v("pre_rst_r5", S_RD0, 32'h1234);
    expect_v("pre_rst_busy", S_BUSY, 32'h2);
    expect_v("pre_rst_tv", S_TV, 32'h1);
    drain();
    #1 reset = 1'b0;
    #1;
    expect_v("rst_r5", S_RD0, 32'h0);
    expect_v("rst_busy", S_BUSY, 32'h0);
    expect_v("rst_tv", S_TV, 32'h0);
    expect_v("rst_td0", S_TD0, 32'h0);
    expect_v("rst_nb_r5", S_NBRD0, 32'h0);
    drain();
    #1 reset = 1'b1;
    tick();
    expect_v("post_rst_r5", S_RD0, 32'h0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
